// File: rtl/skin_ellipse_classifier.sv
// skin_ellipse_classifier
//   Classifies each transformed chroma pair (Cb', Cr') as skin / non-skin with a
//   rotated-ellipse boundary model. It is a 4-stage streaming pipeline with no
//   backpressure, and it keeps a per-frame skin-pixel count.
//
//   Optional feature: define SKIN_LUMA_GATE_EN to pipeline y_in and force
//   skin=0 outside [Y_MIN, Y_MAX]. The latency does not change.
//
// Ports
//   clk          : clock, all logic on posedge
//   rst_n        : synchronous active-low reset
//   in_valid     : pixel qualifier
//   in_sof       : first pixel of frame (qualified by in_valid)
//   in_eof       : last pixel of frame (qualified by in_valid)
//   cb_t, cr_t   : transformed Cb' / Cr'
//   y_in         : aligned luma (luma-gate build only)
//   out_valid    : result qualifier, 4 cycles after input
//   out_skin     : 1 = pixel inside ellipse (0 when out_valid=0)
//   out_sof      : delayed in_sof
//   out_eof      : delayed in_eof
//   frame_count  : skin pixels in last completed frame
//   frame_done   : one-cycle pulse when frame_count updates
module skin_ellipse_classifier #(
  parameter int          CX     = 109,
  parameter int          CY     = 152,
  parameter int          COS_Q8 = -210,
  parameter int          SIN_Q8 = 147,
  parameter int          ECX    = 2,
  parameter int          ECY    = 2,
  parameter int unsigned A2     = 645,
  parameter int unsigned B2     = 197,
  parameter int unsigned CNT_W  = 20
`ifdef SKIN_LUMA_GATE_EN
  ,
  parameter int unsigned Y_MIN  = 16,
  parameter int unsigned Y_MAX  = 235
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [7:0]       cb_t,
  input  logic [7:0]       cr_t,
  input  logic [7:0]       y_in,
  output logic             out_valid,
  output logic             out_skin,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_done
);

  localparam int unsigned DW = 10;  // centred chroma
  localparam int unsigned PW = 20;  // rotation products
  localparam int unsigned RW = 12;  // rotated coordinates
  localparam int unsigned SW = 24;  // squared offsets
  localparam int unsigned LW = 40;  // ellipse compare

  localparam logic signed [DW-1:0] CX_S  = DW'(CX);
  localparam logic signed [DW-1:0] CY_S  = DW'(CY);
  localparam logic signed [PW-1:0] COS_S = PW'(COS_Q8);
  localparam logic signed [PW-1:0] SIN_S = PW'(SIN_Q8);
  localparam logic signed [RW-1:0] ECX_S = RW'(ECX);
  localparam logic signed [RW-1:0] ECY_S = RW'(ECY);
  localparam logic [LW-1:0]        A2_L  = LW'(A2);
  localparam logic [LW-1:0]        B2_L  = LW'(B2);
  localparam logic [LW-1:0]        LIM_L = A2_L * B2_L;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  // Control flags (reset) per stage
  logic s1_valid, s1_sof, s1_eof;
  logic s2_valid, s2_sof, s2_eof;
  logic s3_valid, s3_sof, s3_eof;

  // Datapath registers (no reset)
  logic signed [DW-1:0] s1_dcb, s1_dcr;
  logic signed [RW-1:0] s2_x, s2_y;
  logic [SW-1:0]        s3_sx, s3_sy;

  logic signed [PW-1:0] dcb_e, dcr_e, x_full, y_full;
  logic signed [RW-1:0] s2_x_c, s2_y_c, dx, dy;
  logic signed [SW-1:0] dx_e, dy_e;
  logic [SW-1:0]        s3_sx_c, s3_sy_c;
  logic [LW-1:0]        lhs;
  logic                 skin_c;

  logic [CNT_W-1:0]     acc, acc_add, acc_next;

`ifdef SKIN_LUMA_GATE_EN
  logic [7:0] s1_luma, s2_luma, s3_luma;
`else
  logic unused_y;
  assign unused_y = ^y_in;
`endif

  // Pipeline qualifiers; sof/eof are only carried with a valid pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_sof <= 1'b0; s1_eof <= 1'b0;
      s2_valid <= 1'b0; s2_sof <= 1'b0; s2_eof <= 1'b0;
      s3_valid <= 1'b0; s3_sof <= 1'b0; s3_eof <= 1'b0;
      out_valid <= 1'b0; out_skin <= 1'b0; out_sof <= 1'b0; out_eof <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_sof    <= in_valid & in_sof;
      s1_eof    <= in_valid & in_eof;
      s2_valid  <= s1_valid; s2_sof <= s1_sof; s2_eof <= s1_eof;
      s3_valid  <= s2_valid; s3_sof <= s2_sof; s3_eof <= s2_eof;
      out_valid <= s3_valid;
      out_skin  <= s3_valid & skin_c;
      out_sof   <= s3_sof;
      out_eof   <= s3_eof;
    end
  end

  // S2: rotate the centred chroma and floor-shift back from Q8
  always_comb begin
    dcb_e  = {{(PW-DW){s1_dcb[DW-1]}}, s1_dcb};
    dcr_e  = {{(PW-DW){s1_dcr[DW-1]}}, s1_dcr};
    x_full = COS_S * dcb_e + SIN_S * dcr_e;
    y_full = COS_S * dcr_e - SIN_S * dcb_e;
    s2_x_c = RW'(x_full >>> 8);
    s2_y_c = RW'(y_full >>> 8);
  end

  // S3: offset into the ellipse frame and square
  always_comb begin
    dx      = s2_x - ECX_S;
    dy      = s2_y - ECY_S;
    dx_e    = {{(SW-RW){dx[RW-1]}}, dx};
    dy_e    = {{(SW-RW){dy[RW-1]}}, dy};
    s3_sx_c = dx_e * dx_e;
    s3_sy_c = dy_e * dy_e;
  end

  // S4: ellipse test sx/a^2 + sy/b^2 <= 1, cross-multiplied into 40 bits
  always_comb begin
    lhs    = LW'(s3_sx) * B2_L + LW'(s3_sy) * A2_L;
    skin_c = (lhs <= LIM_L);
`ifdef SKIN_LUMA_GATE_EN
    skin_c = skin_c & (s3_luma >= 8'(Y_MIN)) & (s3_luma <= 8'(Y_MAX));
`endif
  end

  always_ff @(posedge clk) begin
    s1_dcb <= $signed({2'b00, cb_t}) - CX_S;
    s1_dcr <= $signed({2'b00, cr_t}) - CY_S;
    s2_x   <= s2_x_c;
    s2_y   <= s2_y_c;
    s3_sx  <= s3_sx_c;
    s3_sy  <= s3_sy_c;
`ifdef SKIN_LUMA_GATE_EN
    s1_luma <= y_in;
    s2_luma <= s1_luma;
    s3_luma <= s2_luma;
`endif
  end

  // Next accumulator value: sof restarts, otherwise saturating increment
  always_comb begin
    acc_add = acc;
    if (out_skin && (acc != CNT_MAX)) begin
      acc_add = acc + CNT_W'(1);
    end
    acc_next = out_sof ? CNT_W'(out_skin) : acc_add;
  end

  // Frame accumulator, updated as each valid result leaves S4
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_valid) begin
        acc <= acc_next;
        if (out_eof) begin
          frame_count <= acc_next;
          frame_done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_skin_ellipse_classifier.sv
// tb_skin_ellipse_classifier
//   Scoreboard bench: the stimulus pushes expected pixel results and frame
//   counts, computed by an arithmetic ellipse model, and a negedge monitor pops
//   and compares them whenever the DUT presents out_valid / frame_done.
module tb_skin_ellipse_classifier;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_sof, in_eof;
  logic [7:0]  cb_t, cr_t, y_in;
  logic        out_valid, out_skin, out_sof, out_eof, frame_done;
  logic [19:0] frame_count;

  skin_ellipse_classifier dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_eof(in_eof), .cb_t(cb_t), .cr_t(cr_t), .y_in(y_in),
    .out_valid(out_valid), .out_skin(out_skin), .out_sof(out_sof),
    .out_eof(out_eof), .frame_count(frame_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; bit skin; bit sof; bit eof; } pix_t;
  typedef struct { int due; int cnt; } frm_t;

  pix_t pq[$];
  frm_t fq[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int acc_m = 0;
  int last_cnt_m = 0;
  bit mon_en = 1'b0;
  localparam int CMAX = (1 << 20) - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ellipse model straight from the geometric definition
  function automatic bit ref_skin(input int cb, input int cr, input int yy);
    int dcb, dcr, x, y, dx, dy;
    longint lhs;
    dcb = cb - 109;
    dcr = cr - 152;
    x   = (-210 * dcb + 147 * dcr) >>> 8;
    y   = (-210 * dcr - 147 * dcb) >>> 8;
    dx  = x - 2;
    dy  = y - 2;
    lhs = longint'(dx * dx) * 197 + longint'(dy * dy) * 645;
`ifdef SKIN_LUMA_GATE_EN
    if (yy < 16 || yy > 235) return 1'b0;
`else
    if (yy < 0) return 1'b0;
`endif
    return lhs <= longint'(645 * 197);
  endfunction

  task automatic issue(input bit v, input bit s, input bit e,
                       input int cb, input int cr, input int yy);
    bit sk;
    in_valid = v; in_sof = s; in_eof = e;
    cb_t = 8'(cb); cr_t = 8'(cr); y_in = 8'(yy);
    if (v) begin
      sk = ref_skin(cb, cr, yy);
      pq.push_back('{due: cyc + 4, skin: sk, sof: s, eof: e});
      if (s) acc_m = int'(sk);
      else if (acc_m < CMAX) acc_m = acc_m + int'(sk);
      if (e) begin
        fq.push_back('{due: cyc + 5, cnt: acc_m});
        last_cnt_m = acc_m;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic settle();
    idle(8);
    chk("frame_count_hold", 32'(frame_count), 32'(last_cnt_m));
    chk("frame_done_idle", 32'(frame_done), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    @(posedge clk); #1;
    pq.delete();
    fq.delete();
    acc_m = 0;
    last_cnt_m = 0;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_skin", 32'(out_skin), 32'd0);
    chk("rst_out_sof", 32'(out_sof), 32'd0);
    chk("rst_out_eof", 32'(out_eof), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  initial begin
    pix_t p;
    frm_t f;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_valid === 1'b1) begin
          if (pq.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            p = pq.pop_front();
            chk("pix_latency", 32'(cyc), 32'(p.due));
            chk("out_skin", 32'(out_skin), 32'(p.skin));
            chk("out_sof", 32'(out_sof), 32'(p.sof));
            chk("out_eof", 32'(out_eof), 32'(p.eof));
          end
        end else begin
          chk("skin_when_idle", 32'(out_skin), 32'd0);
          if (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            chk("missing_out_valid", 32'(out_valid), 32'd1);
          end
        end
        if (frame_done === 1'b1) begin
          if (fq.size() == 0) begin
            chk("unexpected_frame_done", 32'(frame_done), 32'd0);
          end else begin
            f = fq.pop_front();
            chk("frame_latency", 32'(cyc), 32'(f.due));
            chk("frame_count", 32'(frame_count), 32'(f.cnt));
          end
        end else if (fq.size() > 0 && fq[0].due <= cyc) begin
          f = fq.pop_front();
          chk("missing_frame_done", 32'(frame_done), 32'd1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int cb, cr;
    bit v, s, e;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    cb_t = '0; cr_t = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_pulse();
    mon_en = 1'b1;

    // Centre pixel, then far pixel, each as a 1-pixel frame
    issue(1, 1, 1, 109, 152, 128);
    settle();
    issue(1, 1, 1, 0, 0, 128);
    settle();

    // 6-pixel frame with two bubbles -> 3 skin pixels
    issue(1, 1, 0, 109, 152, 128);
    issue(1, 0, 0, 0, 0, 128);
    idle(1);
    issue(1, 0, 0, 109, 152, 128);
    issue(1, 0, 0, 0, 0, 128);
    idle(1);
    issue(1, 0, 0, 109, 152, 128);
    issue(1, 0, 1, 0, 0, 128);
    settle();

    // Back-to-back frames with adjacent frame_done pulses
    issue(1, 1, 0, 109, 152, 128);
    issue(1, 0, 1, 109, 152, 128);
    issue(1, 1, 1, 0, 0, 128);
    issue(1, 1, 1, 109, 152, 128);
    settle();

    // sof mid-frame discards the partial count
    issue(1, 1, 0, 109, 152, 128);
    issue(1, 0, 0, 109, 152, 128);
    issue(1, 1, 0, 0, 0, 128);
    issue(1, 0, 0, 109, 152, 128);
    issue(1, 0, 1, 109, 152, 128);
    settle();

    // Partial frame without eof leaves frame_count unchanged
    issue(1, 1, 0, 109, 152, 128);
    issue(1, 0, 0, 109, 152, 128);
    settle();

    // Reset mid-frame, then a frame with no sof counts from zero
    issue(1, 1, 0, 109, 152, 128);
    issue(1, 0, 0, 109, 152, 128);
    issue(1, 0, 1, 109, 152, 128);
    reset_pulse();
    issue(1, 0, 0, 109, 152, 128);
    issue(1, 0, 0, 0, 0, 128);
    issue(1, 0, 1, 109, 152, 128);
    settle();

`ifdef SKIN_LUMA_GATE_EN
    // Luma gate bounds
    issue(1, 1, 1, 109, 152, 10);
    issue(1, 1, 1, 109, 152, 128);
    issue(1, 1, 1, 109, 152, 235);
    issue(1, 1, 1, 109, 152, 236);
    issue(1, 1, 1, 109, 152, 16);
    issue(1, 1, 1, 109, 152, 15);
    settle();
`endif

    // Randomized traffic, half near the ellipse, half anywhere
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 4) != 0;
      s = ($urandom % 24) == 0;
      e = ($urandom % 24) == 0;
      if ($urandom % 2) begin
        cb = 109 + int'($urandom_range(0, 70)) - 35;
        cr = 152 + int'($urandom_range(0, 70)) - 35;
      end else begin
        cb = int'($urandom % 256);
        cr = int'($urandom % 256);
      end
      issue(v, s, e, cb, cr, int'($urandom % 256));
    end
    settle();

    chk("pixel_queue_drained", 32'(pq.size()), 32'd0);
    chk("frame_queue_drained", 32'(fq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
